// File: rtl/fp_add_sequencer_pkg.sv
// Shared definitions for the multi-cycle single-precision adder controller:
// field widths, special constants, FSM state encoding and field helpers.
package fp_add_sequencer_pkg;

  localparam int MANT_W  = 24;
  localparam int EXP_W   = 8;
  localparam int SHAMT_W = 8;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_PACK,
    ST_DONE
  } state_t;

  // Zero and denormal operands contribute a zero mantissa.
  function automatic logic [MANT_W-1:0] f_mant(input logic [30:0] x);
    return (x[30:23] == 8'd0) ? '0 : {1'b1, x[22:0]};
  endfunction

  function automatic logic f_is_nan(input logic [30:0] x);
    return (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic f_is_inf(input logic [30:0] x);
    return (x[30:23] == EXP_MAX) && (x[22:0] == 23'd0);
  endfunction

endpackage

// File: rtl/fp_add_sequencer_lzc24.sv
// fp_lzc24: combinational leading-zero counter over a 24-bit mantissa.
// Returns 24 for an all-zero input.
module fp_lzc24 (
  input  logic [23:0] i_data,
  output logic [4:0]  o_count
);

  always_comb begin
    o_count = 5'd24;
    // Ascending scan so the highest set bit wins.
    for (int i = 0; i < 24; i++) begin
      if (i_data[i]) o_count = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: sequences an FP32 add through a shared right-only barrel shifter.
// Define FP_ADD_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_add_sequencer
  import fp_add_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        sum,
  output logic [MANT_W-1:0]  bs_data,
  output logic [SHAMT_W-1:0] bs_amt,
  input  logic [MANT_W-1:0]  bs_result
);

  state_t r_state, w_state_next;

  logic              r_sign_a, r_sign_b;
  logic [EXP_W-1:0]  r_exp_a, r_exp_b;
  logic [MANT_W-1:0] r_mant_a, r_mant_b, r_mant;
  logic              r_zero, r_ovf, r_special;
  logic [31:0]       r_special_res, r_sum;

  logic [EXP_W-1:0]  w_exp_a_in, w_exp_b_in, w_diff;
  logic [MANT_W-1:0] w_mant_a_in, w_mant_b_in, w_mant_rev, w_res_rev;
  logic              w_swap, w_special, w_accept;
  logic [31:0]       w_special_res, w_pack;
  logic [MANT_W:0]   w_sum25;
  logic [4:0]        w_lz;
  logic [EXP_W-1:0]  w_pack_exp;
  logic [22:0]       w_pack_frac;

  assign w_exp_a_in  = a[30:23];
  assign w_exp_b_in  = b[30:23];
  assign w_mant_a_in = f_mant(a[30:0]);
  assign w_mant_b_in = f_mant(b[30:0]);
  assign w_swap      = {w_exp_b_in, w_mant_b_in} > {w_exp_a_in, w_mant_a_in};
  assign w_special   = (w_exp_a_in == EXP_MAX) || (w_exp_b_in == EXP_MAX);
  assign w_accept    = in_valid && (r_state == ST_IDLE);
  assign w_diff      = r_exp_a - r_exp_b;

  always_comb begin
    if (f_is_nan(a[30:0]) || f_is_nan(b[30:0]) ||
        (f_is_inf(a[30:0]) && f_is_inf(b[30:0]) && (a[31] != b[31])))
      w_special_res = QNAN;
    else if (f_is_inf(a[30:0]))
      w_special_res = a;
    else
      w_special_res = b;
  end

  assign w_sum25 = (r_sign_a == r_sign_b) ? ({1'b0, r_mant_a} + {1'b0, r_mant_b})
                                          : ({1'b0, r_mant_a} - {1'b0, r_mant_b});

  // Normalisation left shift is done as reverse -> right shift -> reverse.
  generate
    for (genvar gi = 0; gi < MANT_W; gi++) begin : g_rev
      assign w_mant_rev[gi] = r_mant[MANT_W-1-gi];
      assign w_res_rev[gi]  = bs_result[MANT_W-1-gi];
    end
  endgenerate

  fp_lzc24 u_lzc (
    .i_data  (r_mant),
    .o_count (w_lz)
  );

`ifdef FP_ADD_RNE_EN
  logic              r_guard, r_sticky;
  logic [MANT_W-1:0] w_lost;
  logic              w_round_inc;
  logic [MANT_W:0]   w_mant_rnd;

  // Bits of mantB that fall off the bottom of the alignment shift.
  assign w_lost      = 24'(({r_mant_b, 24'd0}) >> w_diff);
  assign w_round_inc = r_guard && (r_sticky || r_mant[0]);
  assign w_mant_rnd  = {1'b0, r_mant} + {{MANT_W{1'b0}}, w_round_inc};
`endif

  always_comb begin
    w_pack_exp  = r_exp_a;
    w_pack_frac = r_mant[22:0];
`ifdef FP_ADD_RNE_EN
    if (w_mant_rnd[MANT_W]) begin
      w_pack_exp  = r_exp_a + 8'd1;
      w_pack_frac = 23'd0;
    end else begin
      w_pack_frac = w_mant_rnd[22:0];
    end
`endif
    if (r_special)
      w_pack = r_special_res;
    else if (r_ovf || (w_pack_exp == EXP_MAX))
      w_pack = {r_sign_a, EXP_MAX, 23'd0};
    else if (r_zero)
      w_pack = 32'd0;
    else
      w_pack = {r_sign_a, w_pack_exp, w_pack_frac};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    bs_data      = '0;
    bs_amt       = '0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = w_special ? ST_PACK : ST_ALIGN;
      end
      ST_ALIGN: begin
        bs_data      = r_mant_b;
        bs_amt       = w_diff;
        w_state_next = ST_ADD;
      end
      ST_ADD:  w_state_next = ST_NORM;
      ST_NORM: begin
        bs_data      = w_mant_rev;
        bs_amt       = {3'b000, w_lz};
        w_state_next = ST_PACK;
      end
      ST_PACK: w_state_next = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign_a      <= 1'b0;
      r_sign_b      <= 1'b0;
      r_exp_a       <= '0;
      r_exp_b       <= '0;
      r_mant_a      <= '0;
      r_mant_b      <= '0;
      r_mant        <= '0;
      r_zero        <= 1'b0;
      r_ovf         <= 1'b0;
      r_special     <= 1'b0;
      r_special_res <= '0;
      r_sum         <= '0;
`ifdef FP_ADD_RNE_EN
      r_guard       <= 1'b0;
      r_sticky      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_special     <= w_special;
          r_special_res <= w_special_res;
          r_zero        <= 1'b0;
          r_ovf         <= 1'b0;
          if (w_swap) begin
            r_sign_a <= b[31];       r_sign_b <= a[31];
            r_exp_a  <= w_exp_b_in;  r_exp_b  <= w_exp_a_in;
            r_mant_a <= w_mant_b_in; r_mant_b <= w_mant_a_in;
          end else begin
            r_sign_a <= a[31];       r_sign_b <= b[31];
            r_exp_a  <= w_exp_a_in;  r_exp_b  <= w_exp_b_in;
            r_mant_a <= w_mant_a_in; r_mant_b <= w_mant_b_in;
          end
        end
        ST_ALIGN: begin
          r_mant_b <= (w_diff >= 8'd24) ? '0 : bs_result;
`ifdef FP_ADD_RNE_EN
          r_guard  <= w_lost[23];
          r_sticky <= (w_diff > 8'd24) ? (|r_mant_b) : (|w_lost[22:0]);
`endif
        end
        ST_ADD: begin
          if (w_sum25[MANT_W]) begin
            r_mant  <= w_sum25[MANT_W:1];
            r_exp_a <= r_exp_a + 8'd1;
            if (r_exp_a == EXP_MAX - 8'd1) r_ovf <= 1'b1;
`ifdef FP_ADD_RNE_EN
            r_guard  <= w_sum25[0];
            r_sticky <= r_guard || r_sticky;
`endif
          end else begin
            r_mant <= w_sum25[MANT_W-1:0];
          end
        end
        ST_NORM: if (!r_ovf) begin
          // Results that would need a denormal exponent are flushed to +0.
          if ((r_mant == '0) || ({3'b000, w_lz} >= r_exp_a)) begin
            r_zero <= 1'b1;
          end else begin
            r_mant  <= w_res_rev;
            r_exp_a <= r_exp_a - {3'b000, w_lz};
          end
        end
        ST_PACK: r_sum <= w_pack;
        default: ;
      endcase
    end
  end

  assign sum = r_sum;

endmodule
